// File: rtl/mmss_scan_ctrl.sv
// mmss_scan_ctrl: MM:SS stopwatch with a time-multiplexed 4-digit BCD scan output.
// A run/pause FSM gates a one-second prescaler, the seconds and minutes counters
// wrap at 59:59, and one shared tens/ones splitter feeds a registered digit output.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks the minutes-tens digit while min < 10.
module mmss_scan_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [3:0] digit,
    output logic [3:0] digit_sel,
    output logic       blank,
    output logic       running,
    output logic       rollover
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic          r_roll;
    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_scan_idx;
    logic [3:0]    r_digit;
    logic [3:0]    r_sel;
    logic          r_blank;

    logic          w_tick;
    logic [5:0]    w_scan_val;
    logic [2:0]    w_tens;
    logic [3:0]    w_tens_x10_lo;
    logic [3:0]    w_ones;

    assign w_tick = (r_state == S_RUN) && (r_presc == P_LAST);

    // Next-state logic: clear dominates, start_stop toggles between run and pause.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else if (start_stop) begin
            case (r_state)
                S_IDLE:  w_state_next = S_RUN;
                S_RUN:   w_state_next = S_PAUSE;
                S_PAUSE: w_state_next = S_RUN;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Prescaler, seconds/minutes counters and the wrap pulse; a tick on the same
    // edge as start_stop is still counted because counting only looks at r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_roll  <= 1'b0;
        end else if (clear) begin
            r_presc <= '0;
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_roll  <= 1'b0;
        end else begin
            r_roll <= w_tick && (r_sec == 6'd59) && (r_min == 6'd59);
            if (w_tick) begin
                r_presc <= '0;
                if (r_sec == 6'd59) begin
                    r_sec <= 6'd0;
                    if (r_min == 6'd59) begin
                        r_min <= 6'd0;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end else if (r_state == S_RUN) begin
                r_presc <= r_presc + 1'b1;
            end else if (r_state == S_IDLE) begin
                r_presc <= '0;
            end
        end
    end

    // Free-running scan timer: advances the digit index every SCAN_DIV cycles in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
        end else if (r_scan_cnt == S_LAST) begin
            r_scan_cnt <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_scan_val = r_scan_idx[1] ? r_min : r_sec;

    // Shared tens/ones splitter for a 0..59 value. Only the low nibble of 10*tens is
    // kept: ones is known to fit in 4 bits, so mod-16 subtraction gives the exact result.
    always_comb begin
        w_tens        = 3'd0;
        w_tens_x10_lo = 4'd0;
        if (w_scan_val >= 6'd50) begin
            w_tens        = 3'd5;
            w_tens_x10_lo = 4'd2;
        end else if (w_scan_val >= 6'd40) begin
            w_tens        = 3'd4;
            w_tens_x10_lo = 4'd8;
        end else if (w_scan_val >= 6'd30) begin
            w_tens        = 3'd3;
            w_tens_x10_lo = 4'd14;
        end else if (w_scan_val >= 6'd20) begin
            w_tens        = 3'd2;
            w_tens_x10_lo = 4'd4;
        end else if (w_scan_val >= 6'd10) begin
            w_tens        = 3'd1;
            w_tens_x10_lo = 4'd10;
        end
    end

    assign w_ones = w_scan_val[3:0] - w_tens_x10_lo;

    // Registered display outputs: digit, one-hot select and blanking share one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
            r_sel   <= 4'b0001;
            r_blank <= 1'b0;
        end else begin
            r_digit <= r_scan_idx[0] ? {1'b0, w_tens} : w_ones;
            r_sel   <= 4'b0001 << r_scan_idx;
`ifdef LEAD_ZERO_BLANK_EN
            r_blank <= (r_scan_idx == 2'd3) && (r_min < 6'd10);
`else
            r_blank <= 1'b0;
`endif
        end
    end

    assign sec       = r_sec;
    assign min       = r_min;
    assign digit     = r_digit;
    assign digit_sel = r_sel;
    assign blank     = r_blank;
    assign running   = (r_state == S_RUN);
    assign rollover  = r_roll;

endmodule

// File: doc/mmss_scan_ctrl.md
MMSS_SCAN_CTRL -- requirements
Module: mmss_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per one-second tick (>=2).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each display digit is held (>=1).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start_stop  input  1  synchronous single-cycle pulse; toggles run/pause.
REQ-006 clear  input  1  synchronous single-cycle pulse; returns to 00:00 stopped.
REQ-007 sec  output  6  seconds count, 0-59.
REQ-008 min  output  6  minutes count, 0-59.
REQ-009 digit  output  4  BCD value of the currently scanned digit, 0-9.
REQ-010 digit_sel  output  4  one-hot active-high select: bit0 sec ones, bit1 sec tens, bit2 min ones, bit3 min tens.
REQ-011 blank  output  1  1 = current digit must be dark.
REQ-012 running  output  1  1 while FSM is in RUN.
REQ-013 rollover  output  1  one-cycle pulse on 59:59 -> 00:00 wrap.

Function
REQ-014 FSM states IDLE, RUN, PAUSE shall exist; IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN.
REQ-015 clear in any state shall force IDLE, sec=0, min=0, prescaler=0 on the next edge; clear wins over a simultaneous start_stop.
REQ-016 Prescaler shall count 0..TICK_DIV-1 only in RUN; it holds its value in PAUSE and is 0 in IDLE.
REQ-017 Tick = prescaler at TICK_DIV-1 in RUN; on that edge prescaler wraps to 0 and sec increments.
REQ-018 sec 59 on tick -> sec 0, min+1; min 59 and sec 59 on tick -> 00:00, rollover=1 for exactly the following cycle, FSM stays RUN.
REQ-019 start_stop arriving on a tick edge: the tick shall still be counted, then FSM moves to PAUSE.
REQ-020 Scan counter shall run in all states: 2-bit scan index advances (0,1,2,3,0...) every SCAN_DIV cycles.
REQ-021 A single tens/ones splitter shall be time-shared: scan index 0/1 selects sec, 2/3 selects min; index even selects ones, odd selects tens.
REQ-022 digit and digit_sel shall be registered: they reflect scan index and counters sampled one cycle earlier (1-cycle latency).
REQ-023 digit_sel shall always be exactly one-hot after reset exits.
REQ-024 blank shall be 0 except where REQ-030 applies.
REQ-025 running shall be combinational from FSM state (RUN -> 1).

Reset
REQ-026 rst_n low shall asynchronously force: FSM IDLE, sec=0, min=0, prescaler=0, scan index=0, digit=0, digit_sel=4'b0001, blank=0, running=0, rollover=0.
REQ-027 Reset asserted mid-count shall discard all progress; first edge after rst_n rises behaves as IDLE.
REQ-028 start_stop or clear pulses while rst_n low shall be ignored.

Configuration
REQ-029 Macro LEAD_ZERO_BLANK_EN shall select leading-zero blanking.
REQ-030 With LEAD_ZERO_BLANK_EN defined: blank=1 when digit_sel=4'b1000 and min<10 (registered with digit); without it: blank constantly 0.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-031 Reset release, no input, 20 cycles -> sec=0, min=0, running=0, digit_sel cycles 0001,0010,0100,1000 every 2 cycles, digit=0.
REQ-032 start_stop pulse, wait 40 cycles -> running=1, sec=10, min=0; digit shows 0,1,0,0 across one scan round.
REQ-033 Preload to 59:58 in RUN (via counting or force), run 8 cycles -> 00:00, rollover high exactly 1 cycle, running stays 1.
REQ-034 RUN, start_stop at prescaler=2, wait 20 cycles, start_stop -> sec unchanged during pause; next tick 2 cycles after resume.
REQ-035 clear and start_stop in same cycle while RUN at 03:07 -> IDLE, 00:00, running=0.
REQ-036 With LEAD_ZERO_BLANK_EN, min=5 -> blank=1 only while digit_sel=1000; min=12 -> blank never 1; without macro blank never 1.
